pdm_mic_capture: RTL

//  Front end between the on-board PDM microphone (MIC_CLK/MIC_DATA/MIC_LR_SEL) and the fir_top record buffer.

---
 rtl/pdm_mic_capture_if.sv | 14 +
 rtl/pdm_mic_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_capture_if.sv
// PCM sample stream between the PDM capture front end and its consumer.
// The master presents a FIFO head (valid/data/idx); the slave accepts it with ready.
interface pdm_mic_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int IDX_W    = 12
);
  logic                valid;
  logic                ready;
  logic [SAMPLE_W-1:0] data;
  logic [IDX_W-1:0]    idx;

  modport master (output valid, output data, output idx, input ready);
  modport slave  (input valid, input data, input idx, output ready);
endinterface

// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: generates MIC_CLK, ones-counts the PDM stream over
// DECIM-bit windows into signed PCM and streams a burst of indexed samples.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | waiting for en; windows ignored, counters held clear
//  ST_WARMUP  | discarding the first WARMUP windows after start
//  ST_CAPTURE | every window end pushes {pcm, sample_cnt} into the FIFO
//  ST_DONE    | burst complete, done=1, FIFO drains; en=0 returns to idle
module pdm_mic_capture #(
  parameter int CLK_DIV    = 25,
  parameter int DECIM      = 64,
  parameter int SAMPLE_W   = 16,
  parameter int N_SAMPLES  = 4096,
  parameter int WARMUP     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 MIC_CLK,
  input  logic                 MIC_DATA,
  output logic                 MIC_LR_SEL,
  pdm_mic_capture_if.master    out,
  output logic                 done,
  output logic                 overflow
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(DECIM + 1);
  localparam int BW = $clog2(DECIM);
  localparam int IW = $clog2(N_SAMPLES);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int SH = SAMPLE_W - 1 - BW;
  localparam logic [SAMPLE_W-1:0] PCM_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_cnt;
  logic                 mic_clk_q;
  logic                 bit_tick;
  logic                 active;
  logic [CW-1:0]        ones_cnt;
  logic [CW-1:0]        ones_next;
  logic [BW-1:0]        bit_cnt;
  logic [CW-1:0]        win_c_q;
  logic                 win_end_q;
  logic [SAMPLE_W-1:0]  pcm;
  logic [WW-1:0]        warm_cnt;
  logic [IW-1:0]        sample_cnt;
  logic                 push, flush, clr;

  logic [SAMPLE_W-1:0]  mem_data [FIFO_DEPTH];
  logic [IW-1:0]        mem_idx  [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        fifo_cnt;
  logic                 full, pop, wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign MIC_CLK    = mic_clk_q;
  assign MIC_LR_SEL = 1'b0;
  assign done       = (state_q == ST_DONE);

  // Free-running MIC_CLK divider, independent of the capture state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      mic_clk_q <= 1'b0;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt   <= '0;
      mic_clk_q <= ~mic_clk_q;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // A PDM bit is taken on the edge that ends the MIC_CLK high phase.
  assign bit_tick  = (div_cnt == DW'(CLK_DIV - 1)) && mic_clk_q;
  assign active    = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
  assign ones_next = ones_cnt + CW'(MIC_DATA);

  // Window accumulation; windows restart from zero whenever capture starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      win_c_q   <= '0;
      win_end_q <= 1'b0;
    end else if (clr || !active) begin
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      win_end_q <= 1'b0;
    end else begin
      win_end_q <= 1'b0;
      if (bit_tick) begin
        if (bit_cnt == BW'(DECIM - 1)) begin
          win_c_q   <= ones_next;
          win_end_q <= 1'b1;
          ones_cnt  <= '0;
          bit_cnt   <= '0;
        end else begin
          ones_cnt <= ones_next;
          bit_cnt  <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // Ones count to PCM; an all-ones window would overflow to +2^(W-1), so saturate.
  always_comb begin
    pcm = PCM_MAX;
    if (win_c_q != CW'(DECIM)) begin
      pcm = SAMPLE_W'((int'(win_c_q) * 2 - DECIM) * (2 ** SH));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    flush   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_WARMUP;
          flush   = 1'b1;
          clr     = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (win_end_q && (warm_cnt == WW'(WARMUP - 1))) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!en) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (win_end_q) begin
          push = 1'b1;
          if (sample_cnt == IW'(N_SAMPLES - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Warm-up and sample counters; sample_cnt advances even when a sample is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt   <= '0;
      sample_cnt <= '0;
    end else if (clr) begin
      warm_cnt   <= '0;
      sample_cnt <= '0;
    end else begin
      if ((state_q == ST_WARMUP) && win_end_q) warm_cnt <= warm_cnt + WW'(1);
      if (push) sample_cnt <= sample_cnt + IW'(1);
    end
  end

  assign full  = (fifo_cnt == NW'(FIFO_DEPTH));
  assign pop   = (fifo_cnt != '0) && out.ready;
  assign wr_en = push && (!full || pop);

  // Sticky overflow flag, cleared only by a new start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        overflow <= 1'b0;
    else if (clr)                    overflow <= 1'b0;
    else if (push && full && !pop)   overflow <= 1'b1;
  end

  // Output FIFO; no bypass, so a push into an empty FIFO shows valid next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem_data[wr_ptr] <= pcm;
        mem_idx[wr_ptr]  <= sample_cnt;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + NW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - NW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out.valid = (fifo_cnt != '0);
  assign out.data  = mem_data[rd_ptr];
  assign out.idx   = mem_idx[rd_ptr];

endmodule
